bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter MEM_WORDS, default 256, meaning backing-store depth in 32-bit words (power of two).
REQ-002 Parameter BEAT_GAP, default 0, meaning idle cycles inserted between consecutive read beats (0..3).
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 reset_n_i  input  1  asynchronous active-low reset.
REQ-005 read_req_i  input  1  master requests a read burst; level held until grant.
REQ-006 write_req_i  input  1  master requests a write burst; level held until grant.
REQ-007 addr_i  input  32  byte start address; word index = addr_i[log2(MEM_WORDS)+1:2].
REQ-008 size_i  input  4  burst code: 3 = 2 words, 8 = 4 words, 9 = 8 words.
REQ-009 write_data_i  input  64  write beat: [31:0] to word n, [63:32] to word n+1.
REQ-010 write_valid_i  input  1  write beat present this cycle.
REQ-011 grant_o  output  1  transfer owned by current requester.
REQ-012 read_data_o  output  64  read beat: [31:0] = word n, [63:32] = word n+1.
REQ-013 read_valid_o  output  1  read_data_o valid this cycle.
REQ-014 error_o  output  1  one-cycle error pulse; transfer aborted.

Function
REQ-015 States SHALL be RESP_IDLE, RESP_GRANT, RESP_READ, RESP_WRITE, RESP_ERR.
REQ-016 RESP_IDLE: read_req_i -> RESP_GRANT (read); else write_req_i -> RESP_GRANT (write); read wins when both high same cycle.
REQ-017 On leaving RESP_IDLE, addr_i and size_i SHALL be latched; later changes ignored until RESP_IDLE.
REQ-018 Beat count SHALL be words/2: size 3 -> 1, 8 -> 2, 9 -> 4.
REQ-019 RESP_GRANT: grant_o = 1 for one cycle, then -> RESP_READ or RESP_WRITE; grant_o SHALL stay 1 through RESP_READ/RESP_WRITE.
REQ-020 RESP_READ: first beat SHALL appear the cycle after RESP_GRANT; subsequent beats every BEAT_GAP+1 cycles; read_valid_o = 1 only on beat cycles.
REQ-021 Each beat SHALL advance the word index by 2; index wraps modulo MEM_WORDS.
REQ-022 Write beats SHALL be accepted on any RESP_WRITE cycle with write_valid_i = 1; cycles with write_valid_i = 0 SHALL not advance the count.
REQ-023 After the last beat (read issued or write accepted), the block SHALL return to RESP_IDLE next cycle with grant_o = 0.
REQ-024 read_data_o SHALL hold the last beat value between beats; zero until first read.
REQ-025 RESP_ERR: error_o = 1, grant_o = 0 for exactly one cycle, then RESP_IDLE; no memory write in that cycle.
REQ-026 Requests arriving while not RESP_IDLE SHALL be ignored until return to RESP_IDLE.
REQ-027 A read of a word written earlier in the same burst SHALL return the new value (write visible next cycle).

Reset
REQ-028 reset_n_i low SHALL asynchronously force RESP_IDLE, grant_o = 0, read_valid_o = 0, error_o = 0, read_data_o = 0, beat counter = 0.
REQ-029 Backing store contents SHALL NOT be cleared by reset; reset mid-burst SHALL abort with no further memory writes.

Configuration
REQ-030 Macro BUS_RESPONDER_ERR_CHECK_EN defined: size_i not in {3,8,9}, or burst crossing the MEM_WORDS boundary, SHALL go RESP_IDLE -> RESP_ERR instead of RESP_GRANT.
REQ-031 Macro undefined: error_o SHALL be tied 0; unsupported size treated as 1 beat; boundary crossing wraps per REQ-021.

Verification
REQ-032 Write size 9 at addr 0x00, beats 0x0000_0002_0000_0001..0x0000_0008_0000_0007 -> grant 1 cycle after req, 4 beats accepted, RESP_IDLE after 4th; words 0..7 = 1..8.
REQ-033 Read size 9 at addr 0x00 after REQ-032, BEAT_GAP=0 -> read_valid_o 4 consecutive cycles, data 0x..02_..01, 0x..04_..03, 0x..06_..05, 0x..08_..07.
REQ-034 read_req_i and write_req_i both rise same cycle, size 3 -> read serviced first, single beat; write granted only after return to RESP_IDLE.
REQ-035 With ERR_CHECK_EN, read size 5 at 0x10 -> error_o high exactly 1 cycle, grant_o never high; without macro -> 1-beat read, error_o stays 0.
REQ-036 Read size 8 at word MEM_WORDS-2 without macro -> beats from words MEM_WORDS-2/-1 then 0/1; with macro -> error pulse.
REQ-037 Write size 8, reset_n_i low after first beat -> outputs zero immediately, second beat never written, word 0..1 updated, 2..3 unchanged.

Source files
------------

// File: rtl/bus_responder_if.sv
// Bus signal bundle for bus_responder: request/grant handshake, burst
// address and size, 64-bit write and read beats, and the error pulse.
// The master modport drives requests and write beats; the slave modport
// drives grant, read beats and error.
interface bus_responder_if;
  logic        read_req_i;
  logic        write_req_i;
  logic [31:0] addr_i;
  logic [3:0]  size_i;
  logic [63:0] write_data_i;
  logic        write_valid_i;
  logic        grant_o;
  logic [63:0] read_data_o;
  logic        read_valid_o;
  logic        error_o;

  modport master (
    output read_req_i, write_req_i, addr_i, size_i, write_data_i, write_valid_i,
    input  grant_o, read_data_o, read_valid_o, error_o
  );

  modport slave (
    input  read_req_i, write_req_i, addr_i, size_i, write_data_i, write_valid_i,
    output grant_o, read_data_o, read_valid_o, error_o
  );
endinterface

// File: rtl/bus_responder.sv
// bus_responder: burst read/write slave in front of a MEM_WORDS x 32-bit
// backing store. Each beat moves two consecutive words. Reads issue one beat
// every BEAT_GAP+1 cycles; writes take a beat whenever write_valid_i is high.
// Optional feature: define BUS_RESPONDER_ERR_CHECK_EN to reject unsupported
// burst sizes and bursts that run past the end of the store with a one-cycle
// error pulse. Without it, unknown sizes act as a single beat and bursts wrap.
module bus_responder #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned BEAT_GAP  = 0
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  bus_responder_if.slave  bus
);

  localparam int unsigned AW  = $clog2(MEM_WORDS);
  localparam logic [1:0]  GAP = 2'(BEAT_GAP);

  typedef enum logic [2:0] {
    RESP_IDLE,
    RESP_GRANT,
    RESP_READ,
    RESP_WRITE,
    RESP_ERR
  } resp_state_e;

  resp_state_e   state_q,   state_d;
  logic          is_read_q, is_read_d;
  logic [AW-1:0] idx_q,     idx_d;
  logic [2:0]    beats_q,   beats_d;
  logic [1:0]    gap_q,     gap_d;
  logic [63:0]   rdata_q,   rdata_d;

  logic [31:0]   mem_q [MEM_WORDS];
  logic          mem_we;
  logic [AW-1:0] idx_hi;
  logic [63:0]   beat_data;
  logic          beat_fire;

  logic [AW-1:0] req_idx;
  logic [2:0]    req_beats;
  logic          unused_addr;

  // Burst code to beat count; anything unrecognised is a single beat.
  function automatic logic [2:0] beats_for(input logic [3:0] size);
    case (size)
      4'd3:    beats_for = 3'd1;
      4'd8:    beats_for = 3'd2;
      4'd9:    beats_for = 3'd4;
      default: beats_for = 3'd1;
    endcase
  endfunction

  assign req_idx     = bus.addr_i[AW+1:2];
  assign req_beats   = beats_for(bus.size_i);
  assign unused_addr = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};

  // Second word of a beat; the index wraps modulo MEM_WORDS.
  assign idx_hi    = idx_q + AW'(1);
  assign beat_data = {mem_q[idx_hi], mem_q[idx_q]};
  assign beat_fire = (state_q == RESP_READ) && (gap_q == 2'd0);

`ifdef BUS_RESPONDER_ERR_CHECK_EN
  logic        size_ok;
  logic [31:0] req_end;
  logic        req_bad;

  // Reject unknown sizes and bursts whose last word lies past the store.
  always_comb begin
    size_ok = (bus.size_i == 4'd3) || (bus.size_i == 4'd8) || (bus.size_i == 4'd9);
    req_end = 32'(req_idx) + {28'd0, req_beats, 1'b0};
    req_bad = !size_ok || (req_end > 32'(MEM_WORDS));
  end
`endif

  // Next-state, burst bookkeeping and memory write enable.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    is_read_d = is_read_q;
    idx_d     = idx_q;
    beats_d   = beats_q;
    gap_d     = gap_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;

    case (state_q)
      RESP_IDLE: begin
        if (bus.read_req_i || bus.write_req_i) begin
          is_read_d = bus.read_req_i;
          idx_d     = req_idx;
          beats_d   = req_beats;
          gap_d     = 2'd0;
          state_d   = RESP_GRANT;
`ifdef BUS_RESPONDER_ERR_CHECK_EN
          if (req_bad) state_d = RESP_ERR;
`endif
        end
      end

      RESP_GRANT: begin
        state_d = is_read_q ? RESP_READ : RESP_WRITE;
      end

      RESP_READ: begin
        if (gap_q == 2'd0) begin
          rdata_d = beat_data;
          idx_d   = idx_q + AW'(2);
          beats_d = beats_q - 3'd1;
          gap_d   = GAP;
          if (beats_q == 3'd1) state_d = RESP_IDLE;
        end else begin
          gap_d = gap_q - 2'd1;
        end
      end

      RESP_WRITE: begin
        if (bus.write_valid_i) begin
          mem_we  = 1'b1;
          idx_d   = idx_q + AW'(2);
          beats_d = beats_q - 3'd1;
          if (beats_q == 3'd1) state_d = RESP_IDLE;
        end
      end

      RESP_ERR: begin
        state_d = RESP_IDLE;
      end

      default: begin
        state_d = RESP_IDLE;
      end
    endcase
  end

  // Control and read-data registers; reset returns to idle with a clean bus.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n_i) begin
      state_q   <= RESP_IDLE;
      is_read_q <= 1'b0;
      idx_q     <= '0;
      beats_q   <= 3'd0;
      gap_q     <= 2'd0;
      rdata_q   <= 64'd0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      idx_q     <= idx_d;
      beats_q   <= beats_d;
      gap_q     <= gap_d;
      rdata_q   <= rdata_d;
    end
  end

  // Backing store write port: one beat writes two adjacent words.
  always_ff @(posedge clk_i) begin
    // NOTE: the store has no reset; its contents survive reset, and a reset
    // forces the state to idle so mem_we drops and no further beat lands.
    if (mem_we) begin
      mem_q[idx_q]  <= bus.write_data_i[31:0];
      mem_q[idx_hi] <= bus.write_data_i[63:32];
    end
  end

  // Bus outputs: grant spans the whole transfer, read data holds between beats.
  always_comb begin
    bus.grant_o      = (state_q == RESP_GRANT) || (state_q == RESP_READ) ||
                       (state_q == RESP_WRITE);
    bus.read_valid_o = beat_fire;
    bus.read_data_o  = beat_fire ? beat_data : rdata_q;
`ifdef BUS_RESPONDER_ERR_CHECK_EN
    bus.error_o      = (state_q == RESP_ERR);
`else
    bus.error_o      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed testbench for bus_responder (MEM_WORDS=256, BEAT_GAP=0).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_bus_responder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  bus_responder_if bus ();

  bus_responder #(
    .MEM_WORDS (256),
    .BEAT_GAP  (0)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat(input int hi, input int lo);
    return {32'(hi), 32'(lo)};
  endfunction

  task automatic start(input logic rd, input logic [3:0] size, input logic [31:0] addr);
    bus.read_req_i  = rd;
    bus.write_req_i = !rd;
    bus.size_i      = size;
    bus.addr_i      = addr;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    bus.read_req_i    = 1'b0;
    bus.write_req_i   = 1'b0;
    bus.addr_i        = 32'd0;
    bus.size_i        = 4'd0;
    bus.write_data_i  = 64'd0;
    bus.write_valid_i = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_grant", 64'(bus.grant_o), 64'd0);
    check("rst_rvalid", 64'(bus.read_valid_o), 64'd0);
    check("rst_error", 64'(bus.error_o), 64'd0);
    check("rst_rdata", bus.read_data_o, 64'd0);
    rst_n = 1'b1;
    tick();

    // Write 8 words at 0x00 with one stalled cycle: words 0..7 = 1..8
    start(1'b0, 4'd9, 32'h0);
    tick();
    check("wr_grant", 64'(bus.grant_o), 64'd1);
    bus.write_req_i = 1'b0;
    tick();
    check("wr_grant_hold", 64'(bus.grant_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      bus.write_valid_i = 1'b1;
      bus.write_data_i  = beat(2*i+2, 2*i+1);
      tick();
      if (i == 1) begin
        bus.write_valid_i = 1'b0;
        tick();
        check("wr_stall_grant", 64'(bus.grant_o), 64'd1);
      end
    end
    bus.write_valid_i = 1'b0;
    check("wr_done_grant", 64'(bus.grant_o), 64'd0);

    // Read 8 words at 0x00: four back-to-back beats
    start(1'b1, 4'd9, 32'h0);
    tick();
    check("rd_grant", 64'(bus.grant_o), 64'd1);
    check("rd_grant_rvalid", 64'(bus.read_valid_o), 64'd0);
    bus.read_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_beat_valid", 64'(bus.read_valid_o), 64'd1);
      check("rd_beat_data", bus.read_data_o, beat(2*i+2, 2*i+1));
    end
    tick();
    check("rd_end_rvalid", 64'(bus.read_valid_o), 64'd0);
    check("rd_end_grant", 64'(bus.grant_o), 64'd0);
    check("rd_hold_data", bus.read_data_o, beat(8, 7));

    // Simultaneous requests, size 3: read first, then write
    bus.read_req_i  = 1'b1;
    bus.write_req_i = 1'b1;
    bus.size_i      = 4'd3;
    bus.addr_i      = 32'h0;
    tick();
    check("both_grant_rd", 64'(bus.grant_o), 64'd1);
    bus.read_req_i = 1'b0;
    tick();
    check("both_rd_data", bus.read_data_o, beat(2, 1));
    tick();
    check("both_idle_grant", 64'(bus.grant_o), 64'd0);
    check("both_idle_rvalid", 64'(bus.read_valid_o), 64'd0);
    tick();
    check("both_grant_wr", 64'(bus.grant_o), 64'd1);
    bus.write_req_i = 1'b0;
    tick();
    bus.write_valid_i = 1'b1;
    bus.write_data_i  = beat(32'hBB, 32'hAA);
    tick();
    bus.write_valid_i = 1'b0;
    check("both_wr_done", 64'(bus.grant_o), 64'd0);
    start(1'b1, 4'd3, 32'h0);
    tick();
    bus.read_req_i = 1'b0;
    tick();
    check("both_readback", bus.read_data_o, beat(32'hBB, 32'hAA));
    tick();

    // Unsupported size 5 at 0x10
    start(1'b1, 4'd5, 32'h10);
    tick();
`ifdef BUS_RESPONDER_ERR_CHECK_EN
    check("sz5_error", 64'(bus.error_o), 64'd1);
    check("sz5_grant", 64'(bus.grant_o), 64'd0);
    bus.read_req_i = 1'b0;
    tick();
    check("sz5_error_end", 64'(bus.error_o), 64'd0);
    check("sz5_grant_end", 64'(bus.grant_o), 64'd0);
`else
    check("sz5_grant", 64'(bus.grant_o), 64'd1);
    check("sz5_error", 64'(bus.error_o), 64'd0);
    bus.read_req_i = 1'b0;
    tick();
    check("sz5_beat", bus.read_data_o, beat(6, 5));
    check("sz5_rvalid", 64'(bus.read_valid_o), 64'd1);
    tick();
    check("sz5_end_rvalid", 64'(bus.read_valid_o), 64'd0);
    check("sz5_end_error", 64'(bus.error_o), 64'd0);
`endif

    // Burst of 4 words starting at word 254
`ifdef BUS_RESPONDER_ERR_CHECK_EN
    start(1'b1, 4'd8, 32'h3F8);
    tick();
    check("wrap_error", 64'(bus.error_o), 64'd1);
    check("wrap_grant", 64'(bus.grant_o), 64'd0);
    bus.read_req_i = 1'b0;
    tick();
    check("wrap_error_end", 64'(bus.error_o), 64'd0);
`else
    start(1'b0, 4'd8, 32'h3F8);
    tick();
    bus.write_req_i = 1'b0;
    tick();
    bus.write_valid_i = 1'b1;
    bus.write_data_i  = beat(32'h11, 32'h10);
    tick();
    bus.write_data_i  = beat(32'h13, 32'h12);
    tick();
    bus.write_valid_i = 1'b0;
    start(1'b1, 4'd8, 32'h3F8);
    tick();
    bus.read_req_i = 1'b0;
    tick();
    check("wrap_beat0", bus.read_data_o, beat(32'h11, 32'h10));
    tick();
    check("wrap_beat1", bus.read_data_o, beat(32'h13, 32'h12));
    tick();
    check("wrap_end_grant", 64'(bus.grant_o), 64'd0);
`endif

    // Reset after the first beat of a write burst at 0x40
    start(1'b0, 4'd8, 32'h40);
    tick();
    bus.write_req_i = 1'b0;
    tick();
    bus.write_valid_i = 1'b1;
    bus.write_data_i  = beat(32'h21, 32'h20);
    tick();
    bus.write_data_i  = beat(32'h23, 32'h22);
    tick();
    bus.write_valid_i = 1'b0;
    start(1'b0, 4'd8, 32'h40);
    tick();
    bus.write_req_i = 1'b0;
    tick();
    bus.write_valid_i = 1'b1;
    bus.write_data_i  = beat(32'h31, 32'h30);
    tick();
    check("rstmid_grant_before", 64'(bus.grant_o), 64'd1);
    bus.write_data_i = beat(32'h33, 32'h32);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_grant", 64'(bus.grant_o), 64'd0);
    check("rstmid_rvalid", 64'(bus.read_valid_o), 64'd0);
    check("rstmid_error", 64'(bus.error_o), 64'd0);
    check("rstmid_rdata", bus.read_data_o, 64'd0);
    tick();
    bus.write_valid_i = 1'b0;
    rst_n = 1'b1;
    tick();
    start(1'b1, 4'd8, 32'h40);
    tick();
    bus.read_req_i = 1'b0;
    tick();
    check("rstmid_word01", bus.read_data_o, beat(32'h31, 32'h30));
    tick();
    check("rstmid_word23", bus.read_data_o, beat(32'h23, 32'h22));
    tick();
    check("rstmid_end_grant", 64'(bus.grant_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
